// File: rtl/mul_sequencer_if.sv
// -----------------------------------------------------------------------------
// mul_sequencer_if
//   Request/result bundle between the execute stage and mul_sequencer.
//   master : execute stage (drives start/signed_op/op_a/op_b, reads results)
//   slave  : mul_sequencer (reads the request, drives busy/done/err/hi/lo)
//
//   start     request strobe, sampled only while the sequencer is idle
//   signed_op 1 = MULT (signed), 0 = MULTU
//   op_a/op_b multiplicand / multiplier
//   busy      high whenever the sequencer is not idle
//   done      one-cycle completion pulse
//   err       one-cycle timeout flag, coincident with done
//   hi/lo     64-bit product, held until the next completion
// -----------------------------------------------------------------------------
interface mul_sequencer_if;
    logic        start;
    logic        signed_op;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic        busy;
    logic        done;
    logic        err;
    logic [31:0] hi;
    logic [31:0] lo;

    modport master (
        output start, signed_op, op_a, op_b,
        input  busy, done, err, hi, lo
    );

    modport slave (
        input  start, signed_op, op_a, op_b,
        output busy, done, err, hi, lo
    );
endinterface

// File: rtl/mul_sequencer.sv
// -----------------------------------------------------------------------------
// mul_sequencer
//   Front end for the shift-add multiplier core. Accepts a request, converts
//   signed operands to magnitudes, clears and launches the core, waits for its
//   sticky ready (with a timeout), restores the sign and returns HI/LO with a
//   one-cycle done pulse. A timeout returns done+err with a zero result.
//
// Ports
//   clk          clock, rising edge
//   rst          asynchronous active-low reset
//   req          request/result bundle (mul_sequencer_if.slave)
//   core_rst     active-high clear to the core (also held during reset)
//   core_run     one-cycle launch pulse to the core
//   core_mcand   magnitude of op_a, stable from CLR until IDLE
//   core_mplier  magnitude of op_b, stable from CLR until IDLE
//   core_ready   sticky completion flag from the core
//   core_product unsigned 64-bit product from the core
// -----------------------------------------------------------------------------
module mul_sequencer #(
    parameter int TIMEOUT = 40,
    parameter int CNT_W   = 6
) (
    input  logic                 clk,
    input  logic                 rst,
    mul_sequencer_if.slave       req,
    output logic                 core_rst,
    output logic                 core_run,
    output logic [31:0]          core_mcand,
    output logic [31:0]          core_mplier,
    input  logic                 core_ready,
    input  logic [63:0]          core_product
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLR,
        S_RUN,
        S_WAIT,
        S_FIX,
        S_DONE,
        S_ERR
    } state_t;

    state_t             state;
    logic               neg;
    logic [63:0]        prod;
    logic [CNT_W-1:0]   cnt;
    logic               clr_q;
    logic               busy_q;
    logic               done_q;
    logic               err_q;
    logic [31:0]        hi_q;
    logic [31:0]        lo_q;

    // The core must stay cleared for as long as this block is in reset, so
    // the registered CLR strobe is combined with the raw reset here.
    assign core_rst = clr_q | ~rst;

    assign req.busy = busy_q;
    assign req.done = done_q;
    assign req.err  = err_q;
    assign req.hi   = hi_q;
    assign req.lo   = lo_q;

    // All outputs are registered alongside the state: each branch sets the
    // outputs that belong to the state being entered.
    // NOTE: every register here, the result and operand words included, gets
    // a reset value so a reset mid-operation discards all in-flight data.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= S_IDLE;
            neg         <= 1'b0;
            prod        <= '0;
            cnt         <= '0;
            clr_q       <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            hi_q        <= '0;
            lo_q        <= '0;
            core_run    <= 1'b0;
            core_mcand  <= '0;
            core_mplier <= '0;
        end else begin
            // NOTE: non-blocking assignments throughout, so every branch reads
            // the pre-edge values of the state and counter.
            case (state)
                S_IDLE: begin
                    if (req.start) begin
                        neg         <= req.signed_op & (req.op_a[31] ^ req.op_b[31]);
                        // Two's-complement negation of 0x80000000 gives
                        // 0x80000000, which is the correct unsigned magnitude.
                        core_mcand  <= (req.signed_op & req.op_a[31]) ? (~req.op_a + 32'd1) : req.op_a;
                        core_mplier <= (req.signed_op & req.op_b[31]) ? (~req.op_b + 32'd1) : req.op_b;
                        clr_q       <= 1'b1;
                        busy_q      <= 1'b1;
                        state       <= S_CLR;
                    end
                end
                S_CLR: begin
                    clr_q    <= 1'b0;
                    core_run <= 1'b1;
                    state    <= S_RUN;
                end
                S_RUN: begin
                    core_run <= 1'b0;
                    cnt      <= '0;
                    state    <= S_WAIT;
                end
                S_WAIT: begin
                    cnt <= cnt + 1'b1;
                    // Ready is checked first so it wins over a coincident timeout.
                    if (core_ready) begin
                        prod  <= core_product;
                        state <= S_FIX;
                    end else if (cnt == CNT_W'(TIMEOUT - 1)) begin
                        hi_q   <= '0;
                        lo_q   <= '0;
                        done_q <= 1'b1;
                        err_q  <= 1'b1;
                        state  <= S_ERR;
                    end
                end
                S_FIX: begin
                    {hi_q, lo_q} <= neg ? (~prod + 64'd1) : prod;
                    done_q       <= 1'b1;
                    state        <= S_DONE;
                end
                S_DONE, S_ERR: begin
                    done_q <= 1'b0;
                    err_q  <= 1'b0;
                    busy_q <= 1'b0;
                    state  <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mul_sequencer.sv
// -----------------------------------------------------------------------------
// tb_mul_sequencer
//   Self-checking bench for mul_sequencer. A behavioural multiplier core with
//   a programmable latency answers the launch; expected results come from
//   plain 64-bit signed/unsigned arithmetic on the requested operands.
// -----------------------------------------------------------------------------
module tb_mul_sequencer;

    localparam int TIMEOUT = 40;

    logic        clk;
    logic        rst;
    logic        core_rst;
    logic        core_run;
    logic [31:0] core_mcand;
    logic [31:0] core_mplier;
    logic        core_ready;
    logic [63:0] core_product;

    mul_sequencer_if bus ();

    mul_sequencer #(.TIMEOUT(TIMEOUT), .CNT_W(6)) dut (
        .clk          (clk),
        .rst          (rst),
        .req          (bus.slave),
        .core_rst     (core_rst),
        .core_run     (core_run),
        .core_mcand   (core_mcand),
        .core_mplier  (core_mplier),
        .core_ready   (core_ready),
        .core_product (core_product)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Behavioural core: ready rises core_lat edges after the edge that sees
    // core_run, and stays high until cleared. core_lat = 0 models a hung core.
    int core_lat = 33;
    int cd;

    always @(posedge clk) begin
        if (core_rst) begin
            core_ready   <= 1'b0;
            core_product <= '0;
            cd           <= 0;
        end else if (core_run) begin
            cd <= core_lat;
        end else if (cd != 0) begin
            cd <= cd - 1;
            if (cd == 1) begin
                core_ready   <= 1'b1;
                core_product <= {32'b0, core_mcand} * {32'b0, core_mplier};
            end
        end
    end

    function automatic logic [31:0] magnitude(input logic sgn, input logic [31:0] v);
        return (sgn && v[31]) ? 32'(0 - v) : v;
    endfunction

    function automatic logic [63:0] ref_product(input logic sgn, input logic [31:0] a, input logic [31:0] b);
        logic signed [63:0] sa, sb;
        sa = {{32{a[31]}}, a};
        sb = {{32{b[31]}}, b};
        return sgn ? 64'(sa * sb) : ({32'b0, a} * {32'b0, b});
    endfunction

    // One full request. Edge 0 is the accept edge; results are sampled 1 ns
    // after each later edge. While the request is in flight the operand inputs
    // are scrambled and start is pulsed once, none of which may matter.
    task automatic run_op(input string tag, input logic sgn, input logic [31:0] a,
                          input logic [31:0] b, input int lat);
        int          edges, runs, run_at, done_at, busy_low, exp_done_at;
        bit          exp_ok;
        logic [63:0] exp_p;

        exp_ok      = (lat != 0) && (lat + 3 <= TIMEOUT + 2);
        exp_done_at = exp_ok ? lat + 4 : TIMEOUT + 2;
        exp_p       = exp_ok ? ref_product(sgn, a, b) : 64'd0;

        @(negedge clk);
        core_lat      = lat;
        bus.start     = 1'b1;
        bus.signed_op = sgn;
        bus.op_a      = a;
        bus.op_b      = b;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        check({tag, ".busy_clr"},   64'(bus.busy), 64'd1);
        check({tag, ".core_rst"},   64'(core_rst), 64'd1);
        check({tag, ".mcand"},      64'(core_mcand),  64'(magnitude(sgn, a)));
        check({tag, ".mplier"},     64'(core_mplier), 64'(magnitude(sgn, b)));

        edges = 0; runs = 0; run_at = -1; done_at = -1; busy_low = 0;
        while (done_at < 0 && edges < 200) begin
            bus.op_a      = $urandom;
            bus.op_b      = $urandom;
            bus.signed_op = 1'($urandom);
            @(posedge clk);
            #1;
            edges++;
            bus.start = (edges == 10);
            if (core_run) begin
                runs++;
                run_at = edges;
            end
            if (!bus.busy) busy_low++;
            if (bus.done) done_at = edges;
        end
        bus.start = 1'b0;

        // core_run appears in the cycle after the CLR cycle.
        check({tag, ".run_count"}, 64'(runs), 64'd1);
        check({tag, ".run_at"},    64'(run_at), 64'd1);
        check({tag, ".busy_held"}, 64'(busy_low), 64'd0);
        check({tag, ".done_at"},   64'(done_at), 64'(exp_done_at));
        check({tag, ".err"},       64'(bus.err), 64'(!exp_ok));
        check({tag, ".hilo"},      {bus.hi, bus.lo}, exp_p);

        @(posedge clk);
        #1;
        check({tag, ".done_drop"}, 64'(bus.done), 64'd0);
        check({tag, ".busy_drop"}, 64'(bus.busy), 64'd0);
        check({tag, ".hilo_hold"}, {bus.hi, bus.lo}, exp_p);
    endtask

    initial begin
        int   seen_done;
        logic s;
        logic [31:0] a, b;
        int   lat;

        rst           = 1'b0;
        bus.start     = 1'b0;
        bus.signed_op = 1'b0;
        bus.op_a      = '0;
        bus.op_b      = '0;
        #1;
        check("rst.busy",    64'(bus.busy), 64'd0);
        check("rst.done",    64'(bus.done), 64'd0);
        check("rst.err",     64'(bus.err), 64'd0);
        check("rst.hilo",    {bus.hi, bus.lo}, 64'd0);
        check("rst.run",     64'(core_run), 64'd0);
        check("rst.mcand",   64'(core_mcand), 64'd0);
        check("rst.mplier",  64'(core_mplier), 64'd0);
        check("rst.core_rst", 64'(core_rst), 64'd1);
        repeat (2) @(negedge clk);
        rst = 1'b1;

        // Directed cases, including the sign corners.
        run_op("u3x5",     1'b0, 32'd3,          32'd5,          33);
        run_op("s-3x5",    1'b1, 32'hFFFF_FFFD,  32'd5,          33);
        run_op("s8000sq",  1'b1, 32'h8000_0000,  32'h8000_0000,  33);
        run_op("uffffsq",  1'b0, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  33);
        run_op("s5x-7",    1'b1, 32'd5,          32'hFFFF_FFF9,  33);

        // Hung core times out; the next request must complete normally.
        run_op("hang",     1'b0, 32'd12,         32'd34,         0);
        run_op("after",    1'b0, 32'd12,         32'd34,         33);

        // Ready on the very edge the timeout would fire wins; one later loses.
        run_op("edge_ok",  1'b1, 32'hFFFF_FF00,  32'd3,          TIMEOUT - 1);
        run_op("edge_to",  1'b1, 32'hFFFF_FF00,  32'd3,          TIMEOUT);
        run_op("fast",     1'b0, 32'd100,        32'd200,        1);

        // Randomized operands, signedness and core latency.
        for (int i = 0; i < 16; i++) begin
            s   = 1'($urandom);
            a   = $urandom;
            b   = $urandom;
            lat = (i % 4 == 0) ? int'($urandom_range(1, TIMEOUT + 4)) : 33;
            run_op($sformatf("rnd%0d", i), s, a, b, lat);
        end

        // Reset in the middle of WAIT: outputs clear at once, no done appears.
        @(negedge clk);
        core_lat      = 33;
        bus.start     = 1'b1;
        bus.signed_op = 1'b0;
        bus.op_a      = 32'd9;
        bus.op_b      = 32'd9;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        repeat (12) @(posedge clk);
        #2;
        rst = 1'b0;
        #1;
        check("mrst.busy",     64'(bus.busy), 64'd0);
        check("mrst.core_rst", 64'(core_rst), 64'd1);
        check("mrst.mcand",    64'(core_mcand), 64'd0);
        check("mrst.hilo",     {bus.hi, bus.lo}, 64'd0);
        seen_done = 0;
        repeat (3) begin
            @(negedge clk);
            if (bus.done) seen_done++;
        end
        rst = 1'b1;
        repeat (40) begin
            @(negedge clk);
            if (bus.done) seen_done++;
        end
        check("mrst.no_done", 64'(seen_done), 64'd0);

        run_op("post_rst", 1'b0, 32'd7, 32'd6, 33);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
